uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter directly downstream of the accumulator baud-clock generator. It consumes the generated baud clock (same `clk_i` domain) and detects its rising edges to form a one-cycle bit tick. It accepts parallel bytes over a valid/ready handshake and shifts them out LSB-first on `tx_o` as start, data, optional parity and stop bits. Stop and start bits can run back-to-back with no idle gap.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.
- `PARITY_MODE`, default `PAR_NONE`: `PAR_NONE`, `PAR_EVEN` or `PAR_ODD` (type `parity_e` from `uart_pkg`).
- `STOP_BITS`, default 1: legal values 1 or 2.
- `clk_i` input, 1 bit: system clock.
- `rst_i` input, 1 bit: reset, asynchronous, active-high.
- `baud_clk_i` input, 1 bit: baud clock from the accumulator generator, synchronous to `clk_i`.
- `data_i` input, `DATA_BITS` wide: byte to send, sampled on handshake.
- `valid_i` input, 1 bit: `data_i` valid.
- `ready_o` output, 1 bit: block can accept a byte this cycle.
- `tx_o` output, 1 bit: serial line, idle high.
- `busy_o` output, 1 bit: frame in progress (any state other than IDLE).
- `done_o` output, 1 bit: one-cycle pulse after the final stop bit completes.

## Operation
- Tick generation:
  - `tick = baud_clk_i & ~baud_q`, where `baud_q` is `baud_clk_i` registered.
  - One bit period is one full `baud_clk_i` period.
- States: IDLE, ARMED, START, DATA, PARITY, STOP.
- Handshake: a transfer occurs when `valid_i && ready_o` at a `clk_i` rising edge.
  - On transfer, `data_i` is loaded into the shift register.
  - Parity is computed at the same time: XOR of the data for even, inverted XOR for odd.
- State transitions (all state changes except IDLE→ARMED happen only on a tick):
  - IDLE: `ready_o`=1. On transfer go to ARMED; `ready_o`=0 from the next cycle.
  - ARMED: `tx_o`=1. On tick go to START; `tx_o`=0.
  - START: on tick go to DATA; `tx_o`=shift[0]; bit counter cleared.
  - DATA: on tick shift right, counter+1.
    - If counter==`DATA_BITS`-1: go to PARITY (`tx_o`=parity) when parity is enabled, otherwise STOP (`tx_o`=1).
  - PARITY: on tick go to STOP; `tx_o`=1.
  - STOP: on tick, if stop counter==`STOP_BITS`-1, the frame ends; otherwise the stop counter increments.
- Gapless back-to-back frames:
  - `ready_o` is also 1 throughout the final stop bit until a transfer occurs.
  - A transfer there sets `pending`.
  - At frame end with `pending` set, go straight to START (`tx_o`=0); otherwise go to IDLE.
- `done_o` pulses for the cycle after every frame-end tick, whether or not a pending frame follows.
- `valid_i` asserted while `ready_o`=0 has no effect. `data_i` may change freely outside the handshake.

## Timing
- Reset values (asynchronous, immediate): `tx_o`=1, `ready_o`=1, `busy_o`=0, `done_o`=0, state IDLE, `baud_q`=0, `pending`=0, all counters 0.
- All outputs are registered.
- Latency:
  - `tx_o` changes exactly one `clk_i` cycle after the `baud_clk_i` rising edge is sampled.
  - Each line bit lasts exactly one baud period.
- Transfer-to-start-bit latency is between 1 cycle and 1 baud period, because the start bit aligns to the next tick.
- Transfer and tick in the same cycle while in IDLE: go to ARMED only. The start bit waits for the following tick, so the first bit always lasts a full period.
- Reset asserted mid-frame: frame aborted, `tx_o`=1 immediately. No `done_o` pulse.
- `baud_clk_i` held static: FSM freezes and `tx_o` holds its current value.
- Frame length: 1 + `DATA_BITS` + (parity ? 1 : 0) + `STOP_BITS` baud periods.

## Structure
- `uart_pkg` contains:
  - `parity_e` (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`)
  - `tx_state_e`
  - constants `UART_MIN_DATA_BITS`=5, `UART_MAX_DATA_BITS`=9
- Sub-module `uart_tick_det`: rising-edge detector on `baud_clk_i` with async reset, output `tick_o`. The receiver reuses it.
- Elaboration-time assertions on `DATA_BITS` and `STOP_BITS` ranges.

## Test plan
- Common setup: `baud_clk_i` period 16 `clk_i` cycles.
- 8E1, send 0x55 → `tx_o` sequence 0,1,0,1,0,1,0,1,0,0,1, each bit held 16 cycles. `done_o` one pulse; then `ready_o`=1, `busy_o`=0.
- 8O2, send 0x55 → parity bit 1, followed by two stop bits of 16 cycles each; frame spans 12 bit periods.
- 8N1, 0xA5 then 0x3C, with `valid_i` held high → second start bit begins on the tick ending the first stop bit. No idle cycles between frames; two `done_o` pulses 10 periods apart.
- 8N1, assert `rst_i` during data bit 3 of 0xFF → `tx_o`=1 and `ready_o`=1 in the same cycle. No `done_o`. A subsequent 0x00 frame is transmitted correctly.
- 5N1, `valid_i` pulsed while `busy_o`=1 in DATA → ignored; line shows a single frame of 0x1F.
- `baud_clk_i` stopped mid-frame for 100 cycles → `tx_o` constant throughout the stall. Frame resumes correctly when the clock restarts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int UART_MIN_DATA_BITS = 5;
    localparam int UART_MAX_DATA_BITS = 9;
    localparam int UART_CNT_W = $clog2(UART_MAX_DATA_BITS);

endpackage

// File: rtl/uart_tick_det.sv
// Rising-edge detector on the baud clock.
// Emits a one-cycle bit tick in the clk_i domain.
module uart_tick_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic baud_clk_i,
    output logic tick_o
);

    logic baud_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) baud_q <= 1'b0;
        else       baud_q <= baud_clk_i;
    end

    assign tick_o = baud_clk_i & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first start/data/parity/stop framing,
// paced by the baud tick, with gapless back-to-back frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int      DATA_BITS   = 8,
    parameter parity_e PARITY_MODE = PAR_NONE,
    parameter int      STOP_BITS   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baud_clk_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    if (DATA_BITS < UART_MIN_DATA_BITS ||
        DATA_BITS > UART_MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS out of range");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam logic [UART_CNT_W-1:0] LAST_BIT =
        UART_CNT_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic HAS_PAR   = (PARITY_MODE != PAR_NONE);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [UART_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   par_q, par_d;
    logic                   pending_q, pending_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tick;
    logic                   xfer;

    uart_tick_det u_tick (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .baud_clk_i (baud_clk_i),
        .tick_o     (tick)
    );

    assign xfer = valid_i & ready_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            pending_q  <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            pending_q  <= pending_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        pending_d  = pending_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        // Transfers only happen in IDLE or the final stop bit,
        // so loading here never collides with shifting.
        if (xfer) begin
            shift_d = data_i;
            par_d   = (PARITY_MODE == PAR_ODD) ? ~^data_i : ^data_i;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (xfer) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (tick) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = HAS_PAR ? ST_PARITY : ST_STOP;
                        tx_d       = HAS_PAR ? par_q : 1'b1;
                        stop_cnt_d = 1'b0;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (xfer) pending_d = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        done_d     = 1'b1;
                        stop_cnt_d = 1'b0;
                        if (pending_q || xfer) begin
                            state_d   = ST_START;
                            tx_d      = 1'b0;
                            pending_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is open in IDLE and across the final stop bit
    // until a next byte has been taken.
    assign ready_d = (state_d == ST_IDLE) ||
                     (state_d == ST_STOP && stop_cnt_d == LAST_STOP &&
                      !pending_d);
    assign busy_d  = (state_d != ST_IDLE);

    assign tx_o    = tx_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: four configurations decoded
// from the line by a bit-period receiver model.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int      DBITS[4] = '{8, 8, 8, 5};
    localparam int      SBITS[4] = '{1, 2, 1, 1};
    localparam parity_e PCFG[4]  = '{PAR_EVEN, PAR_ODD, PAR_NONE, PAR_NONE};

    logic       clk = 1'b0;
    logic [3:0] rst = 4'h0;
    logic       baud = 1'b0;
    logic       baud_run = 1'b1;
    int         phase = 0;
    logic [8:0] data_v [4];
    logic [3:0] valid = 4'h0;
    logic [3:0] ready, tx, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic baud_p = 1'b0;

    logic [3:0]  rst_seen = 4'h0;
    logic [3:0]  tx_last = 4'hF;
    int          pos[4];
    logic [15:0] fb[4];
    int          frames[4];
    int          start_cyc[4];
    int          last_len[4];
    int          last_done[4];
    int          prev_done[4];
    logic [8:0]  exp_q[4][$];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (baud_run) begin
            phase = (phase + 1) % 16;
            baud  = (phase >= 8);
        end
    end

    uart_tx #(.DATA_BITS(DBITS[0]), .PARITY_MODE(PCFG[0]),
              .STOP_BITS(SBITS[0])) u_8e1 (
        .clk_i(clk), .rst_i(rst[0]), .baud_clk_i(baud),
        .data_i(data_v[0][7:0]), .valid_i(valid[0]),
        .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]),
        .done_o(done[0]));

    uart_tx #(.DATA_BITS(DBITS[1]), .PARITY_MODE(PCFG[1]),
              .STOP_BITS(SBITS[1])) u_8o2 (
        .clk_i(clk), .rst_i(rst[1]), .baud_clk_i(baud),
        .data_i(data_v[1][7:0]), .valid_i(valid[1]),
        .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]),
        .done_o(done[1]));

    uart_tx #(.DATA_BITS(DBITS[2]), .PARITY_MODE(PCFG[2]),
              .STOP_BITS(SBITS[2])) u_8n1 (
        .clk_i(clk), .rst_i(rst[2]), .baud_clk_i(baud),
        .data_i(data_v[2][7:0]), .valid_i(valid[2]),
        .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]),
        .done_o(done[2]));

    uart_tx #(.DATA_BITS(DBITS[3]), .PARITY_MODE(PCFG[3]),
              .STOP_BITS(SBITS[3])) u_5n1 (
        .clk_i(clk), .rst_i(rst[3]), .baud_clk_i(baud),
        .data_i(data_v[3][4:0]), .valid_i(valid[3]),
        .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]),
        .done_o(done[3]));

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int flen(input int i);
        return 1 + DBITS[i] + ((PCFG[i] != PAR_NONE) ? 1 : 0) + SBITS[i];
    endfunction

    // Frame-level reference: data LSB-first, parity over data, stops high.
    task automatic frame_end(input int i);
        logic [8:0] dv;
        int d, p;
        d  = DBITS[i];
        p  = (PCFG[i] != PAR_NONE) ? 1 : 0;
        dv = '0;
        for (int b = 0; b < d; b++) dv[b] = fb[i][1+b];
        if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_frame%0d", i), 1, 0);
        end else begin
            check($sformatf("data%0d", i), dv, exp_q[i].pop_front());
        end
        if (p == 1)
            check($sformatf("parity%0d", i), fb[i][d+1],
                  (^dv) ^ (PCFG[i] == PAR_ODD));
        for (int s = 0; s < SBITS[i]; s++)
            check($sformatf("stop%0d", i), fb[i][1+d+p+s], 1);
        last_len[i] = cyc - start_cyc[i];
        frames[i]++;
    endtask

    always @(posedge clk) begin
        logic rise;
        logic exp_done;
        #1;
        cyc++;
        rise = baud && !baud_p;
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                if (rst_seen[i]) begin
                    pos[i] = 0;
                    rst_seen[i] = 1'b0;
                end else begin
                    exp_done = 1'b0;
                    if (tx[i] !== tx_last[i])
                        check($sformatf("tx_edge%0d", i), rise, 1);
                    if (rise) begin
                        if (pos[i] == flen(i)) begin
                            frame_end(i);
                            exp_done = 1'b1;
                            pos[i] = 0;
                        end
                        if (pos[i] == 0) begin
                            if (tx[i] === 1'b0) begin
                                fb[i][0] = 1'b0;
                                start_cyc[i] = cyc;
                                pos[i] = 1;
                            end
                        end else begin
                            fb[i][pos[i]] = tx[i];
                            pos[i]++;
                        end
                    end
                    if (done[i] !== 1'b0 || exp_done)
                        check($sformatf("done%0d", i), done[i], exp_done);
                    if (done[i] === 1'b1) begin
                        prev_done[i] = last_done[i];
                        last_done[i] = cyc;
                    end
                end
                tx_last[i] = tx[i];
            end
        end
        baud_p = baud;
    end

    task automatic send(input int i, input logic [8:0] d);
        int n;
        logic [8:0] m;
        n = 0;
        m = d & 9'((1 << DBITS[i]) - 1);
        data_v[i] = m;
        valid[i] = 1'b1;
        while (ready[i] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            check($sformatf("send_timeout%0d", i), 0, 1);
        end else begin
            exp_q[i].push_back(m);
        end
        @(negedge clk);
    endtask

    task automatic wait_pos(input int i, input int p);
        int n;
        n = 0;
        while (pos[i] != p && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check($sformatf("pos_timeout%0d", i), 0, 1);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((busy[i] !== 1'b0 || pos[i] != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) check($sformatf("idle_timeout%0d", i), 0, 1);
    endtask

    initial begin
        int f0;
        logic t0;
        for (int i = 0; i < 4; i++) begin
            data_v[i] = '0;
            pos[i] = 0;
            fb[i] = '0;
            frames[i] = 0;
            start_cyc[i] = 0;
            last_len[i] = 0;
            last_done[i] = 0;
            prev_done[i] = 0;
        end
        #1 rst = 4'hF;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_tx", tx[i], 1);
            check("rst_ready", ready[i], 1);
            check("rst_busy", busy[i], 0);
            check("rst_done", done[i], 0);
        end
        repeat (3) @(negedge clk);
        rst = 4'h0;
        mon_en = 1'b1;
        @(negedge clk);

        // 8E1 single frame of 0x55
        send(0, 9'h55);
        valid[0] = 1'b0;
        wait_idle(0);
        check("8e1_frames", frames[0], 1);
        check("8e1_len", last_len[0], 11 * 16);
        check("8e1_ready", ready[0], 1);
        check("8e1_busy", busy[0], 0);

        // 8O2 single frame of 0x55
        send(1, 9'h55);
        valid[1] = 1'b0;
        wait_idle(1);
        check("8o2_frames", frames[1], 1);
        check("8o2_len", last_len[1], 12 * 16);

        // 8N1 gapless pair with valid held high
        send(2, 9'hA5);
        send(2, 9'h3C);
        valid[2] = 1'b0;
        wait_idle(2);
        check("b2b_frames", frames[2], 2);
        check("b2b_done_gap", last_done[2] - prev_done[2], 160);

        // 8N1 reset during data bit 3 of 0xFF
        send(2, 9'hFF);
        valid[2] = 1'b0;
        wait_pos(2, 5);
        repeat (4) @(negedge clk);
        rst[2] = 1'b1;
        rst_seen[2] = 1'b1;
        exp_q[2].delete();
        #1;
        check("abort_tx", tx[2], 1);
        check("abort_ready", ready[2], 1);
        check("abort_busy", busy[2], 0);
        repeat (3) @(negedge clk);
        rst[2] = 1'b0;
        @(negedge clk);
        send(2, 9'h00);
        valid[2] = 1'b0;
        wait_idle(2);
        check("abort_frames", frames[2], 3);

        // 5N1 valid pulse while busy is ignored
        send(3, 9'h1F);
        valid[3] = 1'b0;
        wait_pos(3, 3);
        check("pulse_busy", busy[3], 1);
        check("pulse_ready", ready[3], 0);
        data_v[3] = 9'h0A;
        valid[3] = 1'b1;
        @(negedge clk);
        valid[3] = 1'b0;
        wait_idle(3);
        check("pulse_frames", frames[3], 1);

        // baud stall mid-frame
        f0 = frames[0];
        send(0, 9'($urandom));
        valid[0] = 1'b0;
        wait_pos(0, 4);
        repeat (3) @(negedge clk);
        baud_run = 1'b0;
        t0 = tx[0];
        repeat (50) @(negedge clk);
        check("stall_mid", tx[0], t0);
        repeat (50) @(negedge clk);
        check("stall_end", tx[0], t0);
        baud_run = 1'b1;
        wait_idle(0);
        check("stall_frames", frames[0], f0 + 1);

        // randomized traffic across all configurations
        for (int k = 0; k < 40; k++) begin
            int i;
            i = $urandom_range(0, 3);
            send(i, 9'($urandom));
            if ($urandom_range(0, 2) == 0) send(i, 9'($urandom));
            valid[i] = 1'b0;
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        for (int i = 0; i < 4; i++) wait_idle(i);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("queue_empty", exp_q[i].size(), 0);
            check("final_ready", ready[i], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
